dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the single-port data memory between the CPU load/store path (port 0) and a second requester such as a debug/DMA loader (port 1). It performs at most one memory access per cycle, drives the memory's address, write-data, MemWrite and MemRead lines, and returns registered read data to the winning requester. Arbitration is round-robin, with an optional bounded lock for short bursts.

## Interface
- ADDR_W, 32, address width of requester and memory ports
- DATA_W, 32, data width
- MAX_HOLD, 4, max consecutive locked grants to one port while the other is requesting (≥1)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req0 / req1  in  1  access request, held until granted
- we0 / we1  in  1  1 = write, 0 = read
- lock0 / lock1  in  1  request to keep ownership for a burst
- addr0 / addr1  in  ADDR_W  word address
- wdata0 / wdata1  in  DATA_W  write data
- gnt0 / gnt1  out  1  combinational grant; access is performed this cycle
- rvalid0 / rvalid1  out  1  one-cycle pulse: rdataN is valid
- rdata0 / rdata1  out  DATA_W  registered read data
- mem_addr  out  ADDR_W  to memory r_address
- mem_wdata  out  DATA_W  to memory w_data
- mem_we  out  1  to memory MemWrite
- mem_re  out  1  to memory MemRead
- mem_rdata  in  DATA_W  from memory r_data (combinational read)

## Operation
- State: owner FSM {IDLE, OWN0, OWN1}; rr pointer `last` (last port granted); hold_cnt (0..MAX_HOLD).
- Grant decision each cycle (combinational, rst forces no grant):
  - owner x with lockx=1, reqx=1, and (other req=0 or hold_cnt<MAX_HOLD) -> grant x.
  - else both requesting -> grant port != last.
  - else single requester -> grant it; none -> no grant.
- Exactly one of gnt0/gnt1 high, or neither; never both.
- Granted port drives mem_addr/mem_wdata; mem_we = granted & we; mem_re = granted & ~we. No grant: mem_addr=0, mem_wdata=0, mem_we=0, mem_re=0.
- Edge update: grant to x -> state OWNx, last=x, hold_cnt = (previous owner==x) ? min(hold_cnt+1, MAX_HOLD) : 1. No grant -> IDLE, hold_cnt=0, last unchanged.
- Granted read: rdataX <= mem_rdata, rvalidX <= 1 for the next cycle only; rdataX otherwise holds its last value. Writes produce no rvalid.
- Request consumed at the edge where reqN & gntN; requester may change addr/we/wdata or drop req afterwards.

## Timing
- Reset values: state IDLE, last=1 (port 0 wins first tie), hold_cnt=0, rvalid0/1=0, rdata0/1=0; during rst gnt0/1, mem_we, mem_re=0, so no write occurs on a reset edge.
- Write latency: memory updated at the edge ending the grant cycle.
- Read latency: 1 cycle; rvalid high the cycle after the grant.
- Back-to-back: one access per cycle sustained; alternating ports when both request without lock.
- Starvation bound: waiting port is granted within MAX_HOLD+1 cycles.
- Lock dropped mid-burst: normal round-robin on that cycle.
- Reset mid-operation: pending rvalid cleared; a request held across reset is re-arbitrated from IDLE.

## Test plan
- Reset then req0 read addr 2, mem holds 11 -> gnt0 same cycle, mem_re=1, mem_addr=2; next cycle rvalid0=1, rdata0=11.
- req0 and req1 both held 4 cycles, no lock -> grants 0,1,0,1; mem_addr follows grantee each cycle.
- req1 write addr 5 data 0xDEAD, then req0 read addr 5 -> gnt1 cycle 0, mem_we=1; gnt0 cycle 1; rdata0=0xDEAD cycle 2.
- lock0=1 with req0 and req1 held continuously, MAX_HOLD=4 -> gnt0 for 4 cycles, then gnt1, then gnt0 again.
- No requests -> gnt0/1=0, mem_we=0, mem_re=0, mem_addr=0; state IDLE.
- Assert rst in the cycle a write is requested -> mem_we=0, memory unchanged, rvalid0/1=0 next cycle.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a single-port data memory between two requesters,
// with a bounded lock for short bursts and registered read-data return.
module dmem_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned HoldW = $clog2(MAX_HOLD + 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(MAX_HOLD);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic             rvalid0_q, rvalid1_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;

  // Grant decision: a locked owner keeps the memory until its burst budget runs out.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (state_q == StOwn0 && lock0 && req0 && (!req1 || hold_q < HoldMax)) begin
        gnt0 = 1'b1;
      end else if (state_q == StOwn1 && lock1 && req1 && (!req0 || hold_q < HoldMax)) begin
        gnt1 = 1'b1;
      end else if (req0 && req1) begin
        if (last_q) gnt0 = 1'b1;
        else        gnt1 = 1'b1;
      end else if (req0) begin
        gnt0 = 1'b1;
      end else if (req1) begin
        gnt1 = 1'b1;
      end
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    if (gnt0) begin
      mem_addr  = addr0;
      mem_wdata = wdata0;
      mem_we    = we0;
      mem_re    = ~we0;
    end else if (gnt1) begin
      mem_addr  = addr1;
      mem_wdata = wdata1;
      mem_we    = we1;
      mem_re    = ~we1;
    end
  end

  always_comb begin
    state_d = StIdle;
    last_d  = last_q;
    hold_d  = '0;
    if (gnt0) begin
      state_d = StOwn0;
      last_d  = 1'b0;
      hold_d  = (state_q != StOwn0) ? HoldW'(1) :
                (hold_q == HoldMax) ? HoldMax : hold_q + 1'b1;
    end else if (gnt1) begin
      state_d = StOwn1;
      last_d  = 1'b1;
      hold_d  = (state_q != StOwn1) ? HoldW'(1) :
                (hold_q == HoldMax) ? HoldMax : hold_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      last_q    <= 1'b1;
      hold_q    <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
      rvalid0_q <= gnt0 & ~we0;
      rvalid1_q <= gnt1 & ~we1;
      if (gnt0 && !we0) rdata0_q <= mem_rdata;
      if (gnt1 && !we1) rdata1_q <= mem_rdata;
    end
  end

  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic checked against
// a behavioural model of the arbitration rules and a reference memory.
module tb_dmem_arbiter;
  localparam int MaxHold = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0, lock0 = 1'b0, lock1 = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic        gnt0, gnt1, rvalid0, rvalid1, mem_we, mem_re;
  logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;
  logic        mem_load = 1'b0;
  logic [31:0] tb_mem [16];

  int n_chk = 0;
  int n_err = 0;

  // Reference model state
  int          m_owner = -1;
  int          m_last = 1;
  int          m_hold = 0;
  logic        m_rv0 = 1'b0, m_rv1 = 1'b0;
  logic [31:0] m_rd0 = '0, m_rd1 = '0;
  logic [31:0] ref_mem [16];

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_HOLD(MaxHold)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1), .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = tb_mem[mem_addr[3:0]];

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 16; i++) tb_mem[i] <= 32'(i + 9);
    end else if (mem_we) begin
      tb_mem[mem_addr[3:0]] <= mem_wdata;
    end
  end

  function automatic int exp_gnt();
    if (rst) return -1;
    if (m_owner == 0 && lock0 && req0 && (!req1 || m_hold < MaxHold)) return 0;
    if (m_owner == 1 && lock1 && req1 && (!req0 || m_hold < MaxHold)) return 1;
    if (req0 && req1) return (m_last == 0) ? 1 : 0;
    if (req0) return 0;
    if (req1) return 1;
    return -1;
  endfunction

  task automatic model_edge();
    int g;
    g = exp_gnt();
    if (rst) begin
      m_owner = -1; m_last = 1; m_hold = 0;
      m_rv0 = 1'b0; m_rv1 = 1'b0; m_rd0 = '0; m_rd1 = '0;
      return;
    end
    m_rv0 = 1'b0;
    m_rv1 = 1'b0;
    if (g == 0) begin
      if (!we0) begin m_rv0 = 1'b1; m_rd0 = ref_mem[addr0[3:0]]; end
      else ref_mem[addr0[3:0]] = wdata0;
    end else if (g == 1) begin
      if (!we1) begin m_rv1 = 1'b1; m_rd1 = ref_mem[addr1[3:0]]; end
      else ref_mem[addr1[3:0]] = wdata1;
    end
    if (g >= 0) begin
      m_hold  = (m_owner == g) ? ((m_hold + 1 > MaxHold) ? MaxHold : m_hold + 1) : 1;
      m_owner = g;
      m_last  = g;
    end else begin
      m_owner = -1;
      m_hold  = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set0(input logic r, input logic w, input logic l, input int a,
                      input logic [31:0] d);
    req0 = r; we0 = w; lock0 = l; addr0 = 32'(a); wdata0 = d;
  endtask

  task automatic set1(input logic r, input logic w, input logic l, input int a,
                      input logic [31:0] d);
    req1 = r; we1 = w; lock1 = l; addr1 = 32'(a); wdata1 = d;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'(i + 9);
    rst = 1'b1;
    mem_load = 1'b1;
    set0(1'b1, 1'b0, 1'b0, 3, '0);
    tick();
    mem_load = 1'b0;
    tick();
    @(negedge clk);
    n_chk++;
    if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || mem_re !== 1'b0 || mem_we !== 1'b0) begin
      n_err++;
      $display("FAIL reset_grant: gnt0=%b gnt1=%b re=%b we=%b required all 0",
               gnt0, gnt1, mem_re, mem_we);
    end
    n_chk++;
    if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0 || rdata0 !== 32'h0 || rdata1 !== 32'h0) begin
      n_err++;
      $display("FAIL reset_regs: rv0=%b rv1=%b rd0=%h rd1=%h required 0",
               rvalid0, rvalid1, rdata0, rdata1);
    end
    set0(1'b0, 1'b0, 1'b0, 0, '0);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    set0(1'b1, 1'b0, 1'b0, 2, '0);
    @(negedge clk);
    n_chk++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || mem_re !== 1'b1 || mem_addr !== 32'd2) begin
      n_err++;
      $display("FAIL single_read_req: gnt0=%b gnt1=%b re=%b addr=%0d required 1 0 1 2",
               gnt0, gnt1, mem_re, mem_addr);
    end
    tick();
    set0(1'b0, 1'b0, 1'b0, 0, '0);
    n_chk++;
    if (rvalid0 !== 1'b1 || rdata0 !== 32'd11) begin
      n_err++;
      $display("FAIL single_read_data: rvalid0=%b rdata0=%0d required 1 11", rvalid0, rdata0);
    end
    tick();
    n_chk++;
    if (rvalid0 !== 1'b0) begin
      n_err++;
      $display("FAIL single_read_pulse: rvalid0=%b required 0", rvalid0);
    end
  endtask

  task automatic test_round_robin();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set0(1'b1, 1'b0, 1'b0, 3, '0);
    set1(1'b1, 1'b0, 1'b0, 7, '0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_chk++;
      if (gnt0 !== (i % 2 == 0) || gnt1 !== (i % 2 == 1) ||
          mem_addr !== ((i % 2 == 0) ? 32'd3 : 32'd7)) begin
        n_err++;
        $display("FAIL round_robin[%0d]: gnt0=%b gnt1=%b addr=%0d required gnt0=%0d",
                 i, gnt0, gnt1, mem_addr, (i % 2 == 0));
      end
      tick();
    end
    set0(1'b0, 1'b0, 1'b0, 0, '0);
    set1(1'b0, 1'b0, 1'b0, 0, '0);
    tick();
  endtask

  task automatic test_write_then_read();
    set1(1'b1, 1'b1, 1'b0, 5, 32'hDEAD);
    @(negedge clk);
    n_chk++;
    if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || mem_we !== 1'b1 || mem_wdata !== 32'hDEAD) begin
      n_err++;
      $display("FAIL wr_grant: gnt1=%b gnt0=%b we=%b wdata=%h required 1 0 1 dead",
               gnt1, gnt0, mem_we, mem_wdata);
    end
    tick();
    set1(1'b0, 1'b0, 1'b0, 0, '0);
    set0(1'b1, 1'b0, 1'b0, 5, '0);
    @(negedge clk);
    n_chk++;
    if (gnt0 !== 1'b1 || mem_re !== 1'b1 || rvalid1 !== 1'b0) begin
      n_err++;
      $display("FAIL rd_grant: gnt0=%b re=%b rvalid1=%b required 1 1 0", gnt0, mem_re, rvalid1);
    end
    tick();
    set0(1'b0, 1'b0, 1'b0, 0, '0);
    n_chk++;
    if (rvalid0 !== 1'b1 || rdata0 !== 32'hDEAD) begin
      n_err++;
      $display("FAIL wr_rd_data: rvalid0=%b rdata0=%h required 1 dead", rvalid0, rdata0);
    end
    tick();
  endtask

  task automatic test_lock();
    int seq [6] = '{0, 0, 0, 0, 1, 0};
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set0(1'b1, 1'b0, 1'b1, 1, '0);
    set1(1'b1, 1'b0, 1'b0, 4, '0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_chk++;
      if (gnt0 !== (seq[i] == 0) || gnt1 !== (seq[i] == 1)) begin
        n_err++;
        $display("FAIL lock[%0d]: gnt0=%b gnt1=%b required port %0d", i, gnt0, gnt1, seq[i]);
      end
      tick();
    end
    set0(1'b0, 1'b0, 1'b0, 0, '0);
    set1(1'b0, 1'b0, 1'b0, 0, '0);
    tick();
  endtask

  task automatic test_idle();
    tick();
    @(negedge clk);
    n_chk++;
    if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || mem_we !== 1'b0 || mem_re !== 1'b0 ||
        mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      n_err++;
      $display("FAIL idle: gnt0=%b gnt1=%b we=%b re=%b addr=%h wdata=%h required all 0",
               gnt0, gnt1, mem_we, mem_re, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_reset_during_write();
    set0(1'b1, 1'b0, 1'b0, 2, '0);
    tick();
    set0(1'b0, 1'b0, 1'b0, 0, '0);
    n_chk++;
    if (rvalid0 !== 1'b1) begin
      n_err++;
      $display("FAIL rst_pre_rvalid: rvalid0=%b required 1", rvalid0);
    end
    rst = 1'b1;
    set1(1'b1, 1'b1, 1'b0, 6, 32'hBEEF);
    @(negedge clk);
    n_chk++;
    if (gnt1 !== 1'b0 || mem_we !== 1'b0) begin
      n_err++;
      $display("FAIL rst_write_blocked: gnt1=%b we=%b required 0 0", gnt1, mem_we);
    end
    tick();
    rst = 1'b0;
    n_chk++;
    if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0 || tb_mem[6] !== 32'd15) begin
      n_err++;
      $display("FAIL rst_write_effect: rv0=%b rv1=%b mem6=%h required 0 0 f",
               rvalid0, rvalid1, tb_mem[6]);
    end
    @(negedge clk);
    n_chk++;
    if (gnt1 !== 1'b1 || mem_we !== 1'b1) begin
      n_err++;
      $display("FAIL rst_rearb: gnt1=%b we=%b required 1 1", gnt1, mem_we);
    end
    tick();
    set1(1'b0, 1'b0, 1'b0, 0, '0);
    n_chk++;
    if (tb_mem[6] !== 32'hBEEF) begin
      n_err++;
      $display("FAIL rst_rearb_write: mem6=%h required beef", tb_mem[6]);
    end
  endtask

  task automatic test_random();
    int          g;
    logic [31:0] ea, ed;
    for (int n = 0; n < 400; n++) begin
      rst   = ($urandom_range(0, 39) == 0);
      lock0 = ($urandom_range(0, 3) != 0);
      lock1 = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      g  = exp_gnt();
      ea = (g == 0) ? addr0 : (g == 1) ? addr1 : 32'h0;
      ed = (g == 0) ? wdata0 : (g == 1) ? wdata1 : 32'h0;
      n_chk++;
      if (gnt0 !== (g == 0) || gnt1 !== (g == 1)) begin
        n_err++;
        $display("FAIL rand_gnt[%0d]: gnt0=%b gnt1=%b required port %0d", n, gnt0, gnt1, g);
      end
      n_chk++;
      if (mem_addr !== ea || mem_wdata !== ed ||
          mem_we !== (g == 0 ? we0 : g == 1 ? we1 : 1'b0) ||
          mem_re !== (g == 0 ? ~we0 : g == 1 ? ~we1 : 1'b0)) begin
        n_err++;
        $display("FAIL rand_mem[%0d]: addr=%h wdata=%h we=%b re=%b required addr=%h wdata=%h",
                 n, mem_addr, mem_wdata, mem_we, mem_re, ea, ed);
      end
      n_chk++;
      if (rvalid0 !== m_rv0 || rvalid1 !== m_rv1 || rdata0 !== m_rd0 || rdata1 !== m_rd1) begin
        n_err++;
        $display("FAIL rand_rdata[%0d]: rv0=%b rv1=%b rd0=%h rd1=%h required %b %b %h %h",
                 n, rvalid0, rvalid1, rdata0, rdata1, m_rv0, m_rv1, m_rd0, m_rd1);
      end
      tick();
      // A request stays asserted with fixed fields until it is consumed.
      if (!req0 || g == 0) begin
        set0(($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)), lock0,
             $urandom_range(0, 15), $urandom);
      end
      if (!req1 || g == 1) begin
        set1(($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)), lock1,
             $urandom_range(0, 15), $urandom);
      end
    end
    rst = 1'b0;
    set0(1'b0, 1'b0, 1'b0, 0, '0);
    set1(1'b0, 1'b0, 1'b0, 0, '0);
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_then_read();
    test_lock();
    test_idle();
    test_reset_during_write();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
